regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined uPower/MIPS datapaths, successor to the single-write, dual-read 32x64 file.
- Configurable read/write port counts, registered reads with same-cycle write-to-read bypass, and a per-register busy scoreboard so decode can detect in-flight producers.
- Sits between decode (read, reserve) and writeback (write, clear).

Parameters:
N, 64, register width in bits
R, 32, number of registers
NRD, 2, read ports (1..4)
NWR, 2, write ports (1..2)
ASIZE, $clog2(R), register address width (derived, do not override)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-low reset (0 = reset)
rd_en  in  NRD  per-port read enable
rd_id  in  NRD*ASIZE  read addresses, port p at [p*ASIZE +: ASIZE]
rd_data  out  NRD*N  registered read data, port p at [p*N +: N]
rd_busy  out  NRD  registered: addressed register was busy after this cycle's updates
wr_en  in  NWR  per-port write enable
wr_id  in  NWR*ASIZE  write addresses
wr_data  in  NWR*N  write data
rsv_en  in  1  reserve a destination (set busy)
rsv_id  in  ASIZE  register to reserve
busy_vec  out  R  current busy bit per register (direct from flops)
err_dbl_rsv  out  1  sticky: reserve issued to an already-busy register

Behaviour:
- Reset (rst=0, async): all R registers = 0, busy_vec = 0, rd_data = 0, rd_busy = 0, err_dbl_rsv = 0. Takes effect immediately, including mid-operation; the first posedge after release runs normally.
- Write: at posedge, each port with wr_en=1 stores wr_data into wr_id and clears that register's busy bit.
- Two ports writing the same id in one cycle: the higher port index wins both data and busy clear.
- Writing a non-busy register is legal.
- Reserve: at posedge, rsv_en=1 sets busy[rsv_id].
- Reserve and write to the same id in one cycle: the reserve wins, so busy stays 1 (the new producer supersedes the old one). The data write still happens.
- Reserve to a register that is already busy (before this cycle's writes): busy stays 1 and err_dbl_rsv sets. err_dbl_rsv clears only on reset.
- Read: latency 1. When rd_en[p]=1 at posedge, rd_data[p] and rd_busy[p] are loaded. When rd_en[p]=0, both hold their previous values.
- Bypass (write-first): if rd_id[p] matches an active wr_id in the same cycle, rd_data[p] gets that cycle's winning wr_data, not the old contents.
- rd_busy[p] reflects busy after this cycle's write-clear and reserve-set are applied.
- Out-of-range ids (when R is not a power of 2): writes are ignored, reads return 0 with rd_busy=0, reserves are ignored.

Optional Feature:
- Macro REGFILE_MP_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to zero: writes to id 0 are dropped and do not bypass; reads of id 0 return 0 with rd_busy=0.
  - rsv_en to id 0 is ignored and never sets err_dbl_rsv.
  - busy_vec[0] is always 0.
- Undefined: register 0 behaves like every other register.

Decomposition:
- Shared package regfile_pkg holds:
  - default N/R/NRD/NWR constants
  - a function that slices packed per-port buses
  - a function that resolves the write-port priority match, used for both bypass and busy-clear
- One natural sub-module: regfile_scoreboard. It owns the busy flops, the reserve/clear priority and err_dbl_rsv, and exports busy_vec plus next-busy for rd_busy.

Test Plan:
- Reset mid-run: write 0xDEAD to r5, reserve r7, drop rst for 3 ns between edges -> immediately r5 reads 0, busy_vec=0, rd_data=0, err_dbl_rsv=0.
- Basic write/read: wr port0 r3=0x1234_5678_9ABC_DEF0; next cycle rd_en port1 r3 -> one cycle later rd_data[port1]=0x1234_5678_9ABC_DEF0, rd_busy=0.
- Bypass and write-port conflict, same cycle:
  - wr0 r9=0x11, wr1 r9=0x22, rd0 r9 -> rd_data[0]=0x22 and r9 holds 0x22.
  - rd_en=0 the following cycle -> rd_data[0] holds 0x22.
- Scoreboard:
  - rsv r4 -> busy_vec[4]=1, and a read of r4 gives rd_busy=1.
  - Same cycle: wr r4=0x55 and rsv r4 -> busy_vec[4]=1.
  - Next: wr r4=0x66 alone -> busy_vec[4]=0, and a read of r4 returns 0x66 with rd_busy=0.
- Double reserve: rsv r12 twice on consecutive cycles -> err_dbl_rsv=1 after the second edge and stays 1 until reset.
- With REGFILE_MP_R0_ZERO_EN: wr r0=0xFF, rsv r0, read r0 -> rd_data=0, rd_busy=0, busy_vec[0]=0, err_dbl_rsv=0. Without the macro -> rd_data=0xFF, busy_vec[0]=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and port-bus helpers for the multi-port register file
package regfile_pkg;

  localparam int N_DEF     = 64;
  localparam int R_DEF     = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;

  // Helper functions work on buses widened to these maxima; callers cast in and out.
  localparam int MAX_PORTS = 4;
  localparam int MAX_W     = 128;
  localparam int MAX_BUS   = MAX_PORTS * MAX_W;

  typedef struct packed {
    logic       hit;
    logic [1:0] port;
  } wr_match_t;

  function automatic logic [MAX_W-1:0] port_slice(input logic [MAX_BUS-1:0] bus,
                                                  input int p, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_W; b++)
      if (b < w) r[b] = bus[p*w + b];
    return r;
  endfunction

  // Later ports overwrite earlier matches, so the highest matching index wins.
  function automatic wr_match_t wr_match(input logic [MAX_PORTS-1:0] en,
                                         input logic [MAX_BUS-1:0] ids,
                                         input int nports, input int asize,
                                         input logic [MAX_W-1:0] id);
    wr_match_t m;
    m = '0;
    for (int p = 0; p < MAX_PORTS; p++)
      if (p < nports && en[p] && port_slice(ids, p, asize) == id) begin
        m.hit  = 1'b1;
        m.port = 2'(p);
      end
    return m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with reserve-over-clear priority
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int R     = R_DEF,
  parameter int ASIZE = $clog2(R_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     clr_vec,
  input  logic             rsv_en,
  input  logic [ASIZE-1:0] rsv_id,
  output logic [R-1:0]     busy_vec,
  output logic [R-1:0]     busy_next,
  output logic             err_dbl_rsv
);

  logic [R-1:0] set_vec;

  // rsv_en arrives already qualified (in range, not a hardwired register).
  always_comb begin
    set_vec = '0;
    if (rsv_en) set_vec[rsv_id] = 1'b1;
    busy_next = (busy_vec & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_vec    <= '0;
      err_dbl_rsv <= 1'b0;
    end else begin
      busy_vec <= busy_next;
      if (rsv_en && busy_vec[rsv_id]) err_dbl_rsv <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file, registered write-first reads, busy scoreboard
// Define REGFILE_MP_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int R   = R_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF,
  localparam int ASIZE = $clog2(R)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*ASIZE-1:0] rd_id,
  output logic [NRD*N-1:0]     rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*ASIZE-1:0] wr_id,
  input  logic [NWR*N-1:0]     wr_data,
  input  logic                 rsv_en,
  input  logic [ASIZE-1:0]     rsv_id,
  output logic [R-1:0]         busy_vec,
  output logic                 err_dbl_rsv
);

`ifdef REGFILE_MP_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  function automatic logic id_ok(input logic [ASIZE-1:0] id);
    return (int'(id) < R) && !(R0Z && id == '0);
  endfunction

  logic [N-1:0]     mem [R];
  logic [NWR-1:0]   wr_act;
  logic [ASIZE-1:0] wid [NWR];
  logic [N-1:0]     wdat [NWR];
  logic [ASIZE-1:0] rid [NRD];
  logic [N-1:0]     rd_val [NRD];
  logic [NRD-1:0]   rd_busy_d;
  logic [R-1:0]     clr_vec;
  logic [R-1:0]     busy_next;
  logic             rsv_ok;
  wr_match_t        m;

  always_comb begin
    m         = '0;
    clr_vec   = '0;
    rd_busy_d = '0;
    for (int w = 0; w < NWR; w++) begin
      wid[w]    = ASIZE'(port_slice(MAX_BUS'(wr_id), w, ASIZE));
      wdat[w]   = N'(port_slice(MAX_BUS'(wr_data), w, N));
      wr_act[w] = wr_en[w] && id_ok(wid[w]);
    end
    for (int r = 0; r < R; r++)
      clr_vec[r] = wr_match(MAX_PORTS'(wr_act), MAX_BUS'(wr_id), NWR, ASIZE, MAX_W'(r)).hit;
    for (int p = 0; p < NRD; p++) begin
      rid[p]    = ASIZE'(port_slice(MAX_BUS'(rd_id), p, ASIZE));
      rd_val[p] = '0;
      if (id_ok(rid[p])) begin
        m = wr_match(MAX_PORTS'(wr_act), MAX_BUS'(wr_id), NWR, ASIZE, MAX_W'(rid[p]));
        rd_val[p] = mem[rid[p]];
        for (int w = 0; w < NWR; w++)
          if (m.hit && m.port == 2'(w)) rd_val[p] = wdat[w];
        rd_busy_d[p] = busy_next[rid[p]];
      end
    end
    rsv_ok = rsv_en && id_ok(rsv_id);
  end

  // Ascending port order makes the highest-index write land last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < R; r++) mem[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (wr_act[w]) mem[wid[w]] <= wdat[w];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int p = 0; p < NRD; p++)
        if (rd_en[p]) begin
          rd_data[p*N +: N] <= rd_val[p];
          rd_busy[p]        <= rd_busy_d[p];
        end
    end
  end

  regfile_scoreboard #(.R(R), .ASIZE(ASIZE)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .clr_vec    (clr_vec),
    .rsv_en     (rsv_ok),
    .rsv_id     (rsv_id),
    .busy_vec   (busy_vec),
    .busy_next  (busy_next),
    .err_dbl_rsv(err_dbl_rsv)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (default parameters)
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   rd_en;
  logic [9:0]   rd_id;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic [1:0]   wr_en;
  logic [9:0]   wr_id;
  logic [127:0] wr_data;
  logic         rsv_en;
  logic [4:0]   rsv_id;
  logic [31:0]  busy_vec;
  logic         err_dbl_rsv;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_id(rsv_id),
    .busy_vec(busy_vec), .err_dbl_rsv(err_dbl_rsv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_id = '0; wr_en = '0; wr_id = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_id = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] id, input logic [63:0] d);
    wr_en[p] = 1'b1;
    wr_id[p*5 +: 5] = id;
    wr_data[p*64 +: 64] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] id);
    rd_en[p] = 1'b1;
    rd_id[p*5 +: 5] = id;
  endtask

  task automatic rsv(input logic [4:0] id);
    rsv_en = 1'b1;
    rsv_id = id;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges, checked while held.
  task automatic rst_pulse(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_busy_vec"}, 64'(busy_vec), 64'h0);
    chk({tag, "_rd_data0"}, rd_data[63:0], 64'h0);
    chk({tag, "_rd_data1"}, rd_data[127:64], 64'h0);
    chk({tag, "_err"}, 64'(err_dbl_rsv), 64'h0);
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    cyc();
    chk("reset_busy_vec", 64'(busy_vec), 64'h0);
    chk("reset_rd_data", rd_data[63:0], 64'h0);
    chk("reset_rd_busy", 64'(rd_busy), 64'h0);
    chk("reset_err", 64'(err_dbl_rsv), 64'h0);
    rst = 1'b1;

    // Reset mid-run
    wr(0, 5'd5, 64'hDEAD); rsv(5'd7);
    cyc();
    chk("pre_rst_busy7", 64'(busy_vec[7]), 64'h1);
    idle(); rd(0, 5'd5);
    cyc();
    chk("pre_rst_r5", rd_data[63:0], 64'hDEAD);
    rst_pulse("midrst");
    cyc();
    chk("post_rst_r5", rd_data[63:0], 64'h0);

    // Basic write then read on port 1
    idle(); wr(0, 5'd3, 64'h1234_5678_9ABC_DEF0);
    cyc();
    idle(); rd(1, 5'd3);
    cyc();
    chk("basic_rd1", rd_data[127:64], 64'h1234_5678_9ABC_DEF0);
    chk("basic_busy1", 64'(rd_busy[1]), 64'h0);

    // Same-id write conflict with bypass, then hold
    idle(); wr(0, 5'd9, 64'h11); wr(1, 5'd9, 64'h22); rd(0, 5'd9);
    cyc();
    chk("bypass_rd0", rd_data[63:0], 64'h22);
    idle(); rd_id[4:0] = 5'd3;
    cyc();
    chk("hold_rd0", rd_data[63:0], 64'h22);
    idle(); rd(0, 5'd9); wr(1, 5'd20, 64'hAB); rd(1, 5'd20);
    cyc();
    chk("r9_stored", rd_data[63:0], 64'h22);
    chk("bypass_port1", rd_data[127:64], 64'hAB);

    // Scoreboard
    idle(); rsv(5'd4); rd(0, 5'd4);
    cyc();
    chk("rsv_busy4", 64'(busy_vec[4]), 64'h1);
    chk("rsv_rd_busy", 64'(rd_busy[0]), 64'h1);
    idle(); wr(0, 5'd4, 64'h55); rsv(5'd4);
    cyc();
    chk("rsv_beats_clr", 64'(busy_vec[4]), 64'h1);
    chk("rsv_busy_again_err", 64'(err_dbl_rsv), 64'h1);
    idle(); wr(0, 5'd4, 64'h66); rd(1, 5'd4);
    cyc();
    chk("clr_busy4", 64'(busy_vec[4]), 64'h0);
    chk("clr_rd_data", rd_data[127:64], 64'h66);
    chk("clr_rd_busy", 64'(rd_busy[1]), 64'h0);

    // Double reserve, sticky until reset
    idle();
    rst_pulse("rst2");
    rsv(5'd12);
    cyc();
    chk("dbl_first_err", 64'(err_dbl_rsv), 64'h0);
    chk("dbl_busy12", 64'(busy_vec[12]), 64'h1);
    cyc();
    chk("dbl_second_err", 64'(err_dbl_rsv), 64'h1);
    idle(); wr(1, 5'd12, 64'h7);
    cyc();
    idle();
    cyc();
    chk("dbl_sticky", 64'(err_dbl_rsv), 64'h1);
    chk("dbl_clr12", 64'(busy_vec[12]), 64'h0);
    rst_pulse("rst3");

    // Register 0
    idle(); wr(0, 5'd0, 64'hFF); rsv(5'd0);
    cyc();
    idle(); rd(0, 5'd0);
    cyc();
`ifdef REGFILE_MP_R0_ZERO_EN
    chk("r0_data", rd_data[63:0], 64'h0);
    chk("r0_rd_busy", 64'(rd_busy[0]), 64'h0);
    chk("r0_busy_vec", 64'(busy_vec[0]), 64'h0);
`else
    chk("r0_data", rd_data[63:0], 64'hFF);
    chk("r0_rd_busy", 64'(rd_busy[0]), 64'h1);
    chk("r0_busy_vec", 64'(busy_vec[0]), 64'h1);
`endif
    chk("r0_err", 64'(err_dbl_rsv), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
